// File: rtl/fib_controller.sv
// -----------------------------------------------------------------------------
// fib_controller
//
// Control FSM for a recursive Fibonacci engine (fib(0) = fib(1) = 1). The
// datapath is external and holds the n, f, res and ret registers, an ALU and a
// frame stack. Each recursion level saves a frame {f, n, res}, pushed in that
// order and popped in reverse. The f register records which child call is
// active: 0 means the n-1 call is running, non-zero means the n-2 call is
// running. The final result is left in ret.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          begin on the argument already held in datapath n
//   lt, eq, ready  datapath status: n < 1, n == 1, stack empty
//   f              datapath flag register value
//   busy           high in every state except IDLE
//   done           one-cycle pulse; result valid in datapath ret
//   push, pop      stack strobes
//   addsub         ALU op (0 add, 1 subtract)
//   ress, resld    res mux select (0 ALU, 1 stack) and load
//   rets, retld    ret mux select (0 const 1, 1 ALU, 3 res) and load
//   ns, nld        n mux select (0 ALU, 1 stack) and load
//   fs, fld, frst  f mux select (0 f+1, 1 stack), load, synchronous clear
//   addls          ALU left operand (0 zero, 1 n, 2 res)
//   addrs          ALU right operand (0 f, 1 ret, 2 const 1, 3 const 2)
//   ss             stack input select (0 f, 1 n, 2 res)
//
// state | meaning
// IDLE  | waiting for start; drains stale frames first if stack not empty
// FLUSH | popping leftover frames until the stack is empty
// CALL  | test the base case n <= 1
// PUSHF | push f
// PUSHN | push n
// PUSHR | push res, n <= n-1 or n-2, clear f
// RET   | return: finished if stack empty, else restore caller frame
// POPR  | res <= stack
// POPN  | n <= stack
// POPF  | f <= stack
// DISP  | resume caller: start second child, or sum into ret
// DONE  | one-cycle completion pulse
// -----------------------------------------------------------------------------
module fib_controller #(
    parameter int wordsize = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                lt,
    input  logic                eq,
    input  logic                ready,
    input  logic [wordsize-1:0] f,
    output logic                busy,
    output logic                done,
    output logic                push,
    output logic                pop,
    output logic                addsub,
    output logic                ress,
    output logic                resld,
    output logic [1:0]          rets,
    output logic                retld,
    output logic                ns,
    output logic                nld,
    output logic                fs,
    output logic                fld,
    output logic                frst,
    output logic [1:0]          addls,
    output logic [1:0]          addrs,
    output logic [1:0]          ss
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_CALL,
        S_PUSHF,
        S_PUSHN,
        S_PUSHR,
        S_RET,
        S_POPR,
        S_POPN,
        S_POPF,
        S_DISP,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   f_zero;

    assign f_zero = (f == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        addsub  = 1'b0;
        ress    = 1'b0;
        resld   = 1'b0;
        rets    = 2'd0;
        retld   = 1'b0;
        ns      = 1'b0;
        nld     = 1'b0;
        fs      = 1'b0;
        fld     = 1'b0;
        frst    = 1'b0;
        addls   = 2'd0;
        addrs   = 2'd0;
        ss      = 2'd0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // Stale frames win over a new start; rst gating keeps frst
                // quiet while reset is held.
                if (!ready) begin
                    state_d = S_FLUSH;
                end else if (start && !rst) begin
                    frst    = 1'b1;
                    state_d = S_CALL;
                end
            end
            S_FLUSH: begin
                if (!ready) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALL: begin
                if (lt || eq) begin
                    retld   = 1'b1;
                    rets    = 2'd0;
                    state_d = S_RET;
                end else begin
                    state_d = S_PUSHF;
                end
            end
            S_PUSHF: begin
                push    = 1'b1;
                ss      = 2'd0;
                state_d = S_PUSHN;
            end
            S_PUSHN: begin
                push    = 1'b1;
                ss      = 2'd1;
                state_d = S_PUSHR;
            end
            S_PUSHR: begin
                push    = 1'b1;
                ss      = 2'd2;
                frst    = 1'b1;
                nld     = 1'b1;
                ns      = 1'b0;
                addls   = 2'd1;
                addsub  = 1'b1;
                // f still holds the caller's flag here: first child gets n-1,
                // second child gets n-2.
                addrs   = f_zero ? 2'd2 : 2'd3;
                state_d = S_CALL;
            end
            S_RET: begin
                state_d = ready ? S_DONE : S_POPR;
            end
            S_POPR: begin
                pop     = 1'b1;
                resld   = 1'b1;
                ress    = 1'b1;
                state_d = S_POPN;
            end
            S_POPN: begin
                pop     = 1'b1;
                nld     = 1'b1;
                ns      = 1'b1;
                state_d = S_POPF;
            end
            S_POPF: begin
                pop     = 1'b1;
                fld     = 1'b1;
                fs      = 1'b1;
                state_d = S_DISP;
            end
            S_DISP: begin
                addsub = 1'b0;
                addrs  = 2'd1;
                if (f_zero) begin
                    // Park fib(n-1) in res, flag the second child, recurse.
                    resld   = 1'b1;
                    ress    = 1'b0;
                    addls   = 2'd0;
                    fld     = 1'b1;
                    fs      = 1'b0;
                    state_d = S_PUSHF;
                end else begin
                    retld   = 1'b1;
                    rets    = 2'd1;
                    addls   = 2'd2;
                    state_d = S_RET;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_controller.sv
module tb_fib_controller;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         lt, eq, ready;
    logic [W-1:0] f;
    logic         busy, done, push, pop, addsub, ress, resld, retld;
    logic         ns, nld, fs, fld, frst;
    logic [1:0]   rets, addls, addrs, ss;

    fib_controller #(.wordsize(W)) dut (
        .clk(clk), .rst(rst), .start(start), .lt(lt), .eq(eq), .ready(ready),
        .f(f), .busy(busy), .done(done), .push(push), .pop(pop),
        .addsub(addsub), .ress(ress), .resld(resld), .rets(rets),
        .retld(retld), .ns(ns), .nld(nld), .fs(fs), .fld(fld), .frst(frst),
        .addls(addls), .addrs(addrs), .ss(ss)
    );

    always #5 clk = ~clk;

    // ---------------- external datapath driven by the controller ------------
    logic [W-1:0] dp_n = '0, dp_f = '0, dp_res = '0, dp_ret = '0;
    logic [W-1:0] stk [0:63];
    logic [5:0]   sp = 6'd0;
    logic [W-1:0] top, alu_l, alu_r, alu;
    logic         tb_load = 1'b0;
    logic [W-1:0] tb_n = '0;

    assign lt    = (dp_n == '0);
    assign eq    = (dp_n == W'(1));
    assign ready = (sp == 6'd0);
    assign f     = dp_f;
    assign top   = stk[sp - 6'd1];

    always_comb begin
        case (addls)
            2'd1:    alu_l = dp_n;
            2'd2:    alu_l = dp_res;
            default: alu_l = '0;
        endcase
        case (addrs)
            2'd0:    alu_r = dp_f;
            2'd1:    alu_r = dp_ret;
            2'd2:    alu_r = W'(1);
            default: alu_r = W'(2);
        endcase
        alu = addsub ? alu_l - alu_r : alu_l + alu_r;
    end

    always @(posedge clk) begin
        if (push) begin
            stk[sp] <= (ss == 2'd0) ? dp_f : (ss == 2'd1) ? dp_n : dp_res;
            sp      <= sp + 6'd1;
        end else if (pop) begin
            sp <= sp - 6'd1;
        end
        if (resld) dp_res <= ress ? top : alu;
        if (retld) dp_ret <= (rets == 2'd0) ? W'(1) : (rets == 2'd1) ? alu :
                             (rets == 2'd3) ? dp_res : '0;
        if (tb_load)  dp_n <= tb_n;
        else if (nld) dp_n <= ns ? top : alu;
        if (frst)     dp_f <= '0;
        else if (fld) dp_f <= fs ? top : dp_f + W'(1);
    end

    logic [20:0] all_o;
    assign all_o = {busy, done, push, pop, addsub, ress, resld, rets, retld,
                    ns, nld, fs, fld, frst, addls, addrs, ss};

    // ---------------- behavioural model ----------------
    // x(0) = x(1) = base, x(i) = k + x(i-1) + x(i-2)
    //   fib result      : base 1, k 0
    //   call-to-return  : base 1 (CALL->RET), k 17 (4 push-side + 5 pop-side
    //                     + 3 re-push + 5 pop-side cycles)
    //   push strobes    : base 0, k 6 (two 3-word frames per internal node)
    function automatic int seq_m(input int n, input int base, input int k);
        int a, b, t;
        a = base;
        b = base;
        for (int i = 2; i <= n; i++) begin
            t = k + a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    int vectors = 0, miscompares = 0;
    int push_cnt = 0, pop_cnt = 0, done_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; sample at the falling edge and apply the per-cycle
    // invariants of the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (push) push_cnt++;
        if (pop)  pop_cnt++;
        if (done) done_cnt++;
        if (push && pop) check("push_and_pop", 1, 0);
        if (done) check("done_stack_empty", int'(ready), 1);
    endtask

    task automatic run_fib(input int nv, input int exp_res, input int exp_lat,
                           input bit extra_start);
        int edges, p0, q0, d0;
        bit seen;
        tb_n = W'(nv);
        tb_load = 1'b1;
        tick();
        tb_load = 1'b0;
        p0 = push_cnt; q0 = pop_cnt; d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("n%0d_busy_after_start", nv), int'(busy), 1);
        edges = 1;
        seen = 1'b0;
        while (!seen && edges < 3000) begin
            if (extra_start && edges == 5) start = 1'b1;
            if (extra_start && edges == 8) start = 1'b0;
            tick();
            edges++;
            if (busy !== 1'b1) check($sformatf("n%0d_busy_cont", nv), int'(busy), 1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check($sformatf("n%0d_done_seen", nv), int'(seen), 1);
        check($sformatf("n%0d_latency", nv), edges, 2 + seq_m(nv, 1, 17));
        check($sformatf("n%0d_latency_lit", nv), edges, exp_lat);
        check($sformatf("n%0d_result", nv), int'(dp_ret), seq_m(nv, 1, 0) % 256);
        check($sformatf("n%0d_result_lit", nv), int'(dp_ret), exp_res);
        check($sformatf("n%0d_pushes", nv), push_cnt - p0, seq_m(nv, 0, 6));
        check($sformatf("n%0d_pops", nv), pop_cnt - q0, push_cnt - p0);
        check($sformatf("n%0d_ready_at_done", nv), int'(ready), 1);
        tick();
        check($sformatf("n%0d_idle_after", nv), int'(busy), 0);
        check($sformatf("n%0d_done_pulses", nv), done_cnt - d0, 1);
    endtask

    initial begin
        int k, q0, d0;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_outputs_zero", int'(all_o), 0);
        tick();
        check("rst_outputs_zero_held", int'(all_o), 0);
        start = 1'b0;
        rst = 1'b0;
        #1;
        check("release_outputs_zero", int'(all_o), 0);
        tick();
        check("idle_outputs_zero", int'(all_o), 0);

        run_fib(1, 1, 3, 1'b0);
        run_fib(0, 1, 3, 1'b0);
        run_fib(2, 2, 21, 1'b0);
        run_fib(5, 8, 129, 1'b0);
        run_fib(3, 3, 39, 1'b1);

        // Reset in the middle of an n=4 run, while the second frame word is
        // being pushed; one frame word is left on the stack.
        tb_n = W'(4);
        tb_load = 1'b1;
        tick();
        tb_load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!push && k < 20) begin tick(); k++; end
        check("mid_first_push", int'(push), 1);
        check("mid_first_push_ss", int'(ss), 0);
        tick();
        check("mid_second_push_ss", int'(ss), 1);
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("mid_rst_outputs_zero", int'(all_o), 0);
        q0 = pop_cnt; d0 = done_cnt;
        tick();
        check("mid_rst_held_zero", int'(all_o), 0);
        check("mid_stack_left", int'(ready), 0);
        rst = 1'b0;
        #1;
        check("mid_release_zero", int'(all_o), 0);
        tick();
        check("flush_busy", int'(busy), 1);
        check("flush_pop", int'(pop), 1);
        start = 1'b0;
        k = 0;
        while (busy && k < 20) begin tick(); k++; end
        check("flush_back_idle", int'(busy), 0);
        check("flush_ready", int'(ready), 1);
        check("flush_pop_count", pop_cnt - q0, 1);
        check("flush_no_done", done_cnt - d0, 0);
        tick();
        check("flush_start_dropped", int'(busy), 0);

        run_fib(4, 5, 75, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
